seg7_display_ctrl: RTL and testbench

- Memory-mapped, parametrised N-digit seven-segment display peripheral on the processor's simple write bus.
- A data-register write loads a value; a sequential double-dabble converter turns it into BCD, or hex mode bypasses conversion.
- The result is copied atomically into a display buffer, and a refresh scanner multiplexes the digits onto shared segment and anode pins.
- Adds leading-zero blanking, a per-digit decimal-point mask, overflow indication, and a busy flag.

---
 rtl/seg7_pkg.sv | 42 ++++
 rtl/seg7_bin2bcd_seq.sv | 100 ++++++++++
 rtl/seg7_display_ctrl.sv | 141 ++++++++++++++
 tb/tb_seg7_display_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment display peripheral.
// Holds the glyph table, the internal digit codes that extend the
// hex digits with dash and blank, the converter state type, the control
// register bit positions and the control register offset.
package seg7_pkg;

    localparam int unsigned CTRL_OFFSET = 4;

    // Control register bit positions.
    localparam int unsigned CTRL_EN     = 0;
    localparam int unsigned CTRL_BLANK  = 1;
    localparam int unsigned CTRL_HEX    = 2;
    localparam int unsigned CTRL_DP_LSB = 8;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } conv_state_t;

    // Internal 5-bit digit codes: 0x00-0x0F are hex digits, bit 4 marks a special glyph.
    localparam logic [4:0] CODE_DASH  = 5'h10;
    localparam logic [4:0] CODE_BLANK = 5'h11;

    // Active-high glyphs, bit order {g,f,e,d,c,b,a}; element i is the glyph of digit i.
    localparam logic [15:0][6:0] GLYPH_HEX = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };
    localparam logic [6:0] GLYPH_DASH  = 7'h40;
    localparam logic [6:0] GLYPH_BLANK = 7'h00;

    function automatic logic [6:0] glyph(input logic [4:0] code);
        if (code == CODE_DASH)
            return GLYPH_DASH;
        else if (code[4])
            return GLYPH_BLANK;
        else
            return GLYPH_HEX[code[3:0]];
    endfunction

endpackage

// File: rtl/seg7_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : one-cycle pulse; restarts any conversion in flight
//   hex        : sampled with start; bypasses conversion (raw nibbles)
//   din        : value to convert, sampled with start
//   busy       : high from the cycle after start through DONE
//   done       : high for the single DONE cycle; bcd/overflow are valid
//   overflow   : value does not fit in N_DIGITS digits
//   bcd        : N_DIGITS packed BCD (or hex) digits
module seg7_bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned N_DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  hex,
    input  logic [DATA_W-1:0]     din,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*N_DIGITS-1:0] bcd
);

    localparam int unsigned BCD_W = 4 * N_DIGITS;
    localparam int unsigned CNT_W = $clog2(DATA_W + 1);

    conv_state_t       state;
    logic [DATA_W-1:0] sh;
    logic [CNT_W-1:0]  cnt;
    logic [BCD_W-1:0]  adj;
    logic              hi_bits;

    // Add-3 correction on every digit that is 5 or more.
    always_comb begin
        adj = bcd;
        for (int unsigned i = 0; i < N_DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    assign hi_bits = (din >> BCD_W) != '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            sh       <= '0;
            cnt      <= '0;
            bcd      <= '0;
            overflow <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else if (start) begin
            busy <= 1'b1;
            if (hex) begin
                bcd      <= din[BCD_W-1:0];
                overflow <= hi_bits;
                done     <= 1'b1;
                state    <= DONE;
            end else begin
                bcd      <= '0;
                sh       <= din;
                cnt      <= CNT_W'(DATA_W - 1);
                overflow <= 1'b0;
                done     <= 1'b0;
                state    <= SHIFT;
            end
        end else begin
            case (state)
                SHIFT: begin
                    bcd <= {adj[BCD_W-2:0], sh[DATA_W-1]};
                    sh  <= {sh[DATA_W-2:0], 1'b0};
                    // A 1 leaving the top digit means a digit beyond N_DIGITS would be non-zero.
                    if (adj[BCD_W-1])
                        overflow <= 1'b1;
                    if (cnt == '0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/seg7_display_ctrl.sv
// Memory-mapped N-digit multiplexed seven-segment display controller.
//   clk, rst_n      : clock, asynchronous active-low reset
//   WE, address,
//   dataout         : simple write bus; value at BASE_ADDR, control at BASE_ADDR+4
//   seg             : segments {g,f,e,d,c,b,a} of the active digit
//   dp              : decimal point of the active digit
//   an              : one-hot digit enable, an[0] is the rightmost digit
//   busy            : conversion in progress
//   overflow        : last converted value did not fit in N_DIGITS digits
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned       N_DIGITS    = 4,
    parameter int unsigned       DATA_W      = 32,
    parameter logic [DATA_W-1:0] BASE_ADDR   = 32'h0148,
    parameter int unsigned       REFRESH_DIV = 100000,
    parameter bit                ACTIVE_LOW  = 1'b1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                WE,
    input  logic [DATA_W-1:0]   address,
    input  logic [DATA_W-1:0]   dataout,
    output logic [6:0]          seg,
    output logic                dp,
    output logic [N_DIGITS-1:0] an,
    output logic                busy,
    output logic                overflow
);

    localparam int unsigned RC_W  = $clog2(REFRESH_DIV);
    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    logic                          wr_value, wr_ctrl;
    logic [DATA_W-1:0]             value_q;
    logic                          start_q;
    logic                          ctrl_en, ctrl_blank, ctrl_hex;
    logic [N_DIGITS-1:0]           dp_mask;

    logic                          conv_done, conv_ovf;
    logic [4*N_DIGITS-1:0]         conv_bcd;

    logic [N_DIGITS-1:0][4:0]      buf_code;
    logic [RC_W-1:0]               rc;
    logic [IDX_W-1:0]              idx;
    logic [N_DIGITS-1:0]           lz;
    logic                          run;
    logic [4:0]                    cur_code;

    assign wr_value = WE && (address == BASE_ADDR);
    assign wr_ctrl  = WE && (address == BASE_ADDR + DATA_W'(CTRL_OFFSET));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value_q    <= '0;
            start_q    <= 1'b0;
            ctrl_en    <= 1'b1;
            ctrl_blank <= 1'b0;
            ctrl_hex   <= 1'b0;
            dp_mask    <= '0;
        end else begin
            start_q <= wr_value;
            if (wr_value)
                value_q <= dataout;
            if (wr_ctrl) begin
                ctrl_en    <= dataout[CTRL_EN];
                ctrl_blank <= dataout[CTRL_BLANK];
                ctrl_hex   <= dataout[CTRL_HEX];
                dp_mask    <= dataout[CTRL_DP_LSB +: N_DIGITS];
            end
        end
    end

    seg7_bin2bcd_seq #(
        .DATA_W   (DATA_W),
        .N_DIGITS (N_DIGITS)
    ) u_conv (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start_q),
        .hex      (ctrl_hex),
        .din      (value_q),
        .busy     (busy),
        .done     (conv_done),
        .overflow (conv_ovf),
        .bcd      (conv_bcd)
    );

    // A restart arriving in the DONE cycle discards that result (latest write wins).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_code <= '0;
            overflow <= 1'b0;
        end else if (conv_done && !start_q) begin
            overflow <= conv_ovf;
            for (int unsigned i = 0; i < N_DIGITS; i++)
                buf_code[i] <= conv_ovf ? CODE_DASH : {1'b0, conv_bcd[4*i +: 4]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rc  <= '0;
            idx <= '0;
        end else if (rc == RC_W'(REFRESH_DIV - 1)) begin
            rc  <= '0;
            idx <= (idx == IDX_W'(N_DIGITS - 1)) ? '0 : idx + 1'b1;
        end else begin
            rc <= rc + 1'b1;
        end
    end

    // lz[i]: digits i..N_DIGITS-1 are all zero (dash code is non-zero, so never blanked).
    always_comb begin
        lz  = '0;
        run = 1'b1;
        for (int unsigned k = 0; k < N_DIGITS; k++) begin
            run = run && (buf_code[N_DIGITS-1-k] == 5'd0);
            lz[N_DIGITS-1-k] = run;
        end
    end

    always_comb begin
        cur_code = buf_code[idx];
        if (ctrl_blank && (idx != '0) && lz[idx])
            cur_code = CODE_BLANK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= {7{ACTIVE_LOW}};
            dp  <= ACTIVE_LOW;
            an  <= {N_DIGITS{ACTIVE_LOW}};
        end else begin
            seg <= glyph(cur_code) ^ {7{ACTIVE_LOW}};
            dp  <= dp_mask[idx] ^ ACTIVE_LOW;
            an  <= (ctrl_en ? (N_DIGITS'(1) << idx) : '0) ^ {N_DIGITS{ACTIVE_LOW}};
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
module tb_seg7_display_ctrl;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned RDIV = 4;
    localparam logic [31:0] BASE = 32'h0000_0148;
    localparam logic [31:0] CTRL = 32'h0000_014C;

    // Active-low glyphs, {g,f,e,d,c,b,a}
    localparam logic [6:0] L0 = 7'h40, L1 = 7'h79, L2 = 7'h24, L3 = 7'h30;
    localparam logic [6:0] L4 = 7'h19, L7 = 7'h78, L9 = 7'h10;
    localparam logic [6:0] LB = 7'h03, LE = 7'h06, LF = 7'h0E;
    localparam logic [6:0] LDASH = 7'h3F, LBLANK = 7'h7F;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          WE = 1'b0;
    logic [31:0]   address = '0;
    logic [31:0]   dataout = '0;
    logic [6:0]    seg;
    logic          dp;
    logic [N-1:0]  an;
    logic          busy;
    logic          overflow;

    typedef struct packed {
        logic [N-1:0][6:0] seg;
        logic [N-1:0]      dp_n;
        logic              ovf;
    } frame_t;

    frame_t exp_q[$];
    string  name_q[$];
    int     checks = 0;
    int     errors = 0;
    bit     mon_active = 1'b0;
    bit     force_frame = 1'b0;
    logic   prev_busy = 1'b0;

    seg7_display_ctrl #(
        .N_DIGITS    (N),
        .DATA_W      (DW),
        .BASE_ADDR   (BASE),
        .REFRESH_DIV (RDIV),
        .ACTIVE_LOW  (1'b1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .WE       (WE),
        .address  (address),
        .dataout  (dataout),
        .seg      (seg),
        .dp       (dp),
        .an       (an),
        .busy     (busy),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired", name);
    endtask

    task automatic push(input string name, input logic [6:0] s3, input logic [6:0] s2,
                        input logic [6:0] s1, input logic [6:0] s0,
                        input logic [3:0] dpn, input logic ovf);
        frame_t f;
        f.seg  = {s3, s2, s1, s0};
        f.dp_n = dpn;
        f.ovf  = ovf;
        exp_q.push_back(f);
        name_q.push_back(name);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        WE = 1'b1; address = a; dataout = d;
        @(negedge clk);
        WE = 1'b0; address = '0; dataout = '0;
    endtask

    task automatic measure_busy(input string name, input int exp);
        int cnt = 0;
        int n = 0;
        while (n < 200) begin
            if (busy === 1'b1) cnt++;
            else if (cnt > 0) break;
            @(negedge clk);
            n++;
        end
        chk(name, 32'(cnt), 32'(exp));
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || mon_active || force_frame) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_bound("idle_timeout");
    endtask

    // Monitor: one expected frame per completed conversion; checks all digits over one scan.
    task automatic check_frame();
        frame_t       f;
        string        nm;
        int           idx, last_idx, zeros, n;
        logic [N-1:0] last_an;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_frame: conversion completed with no expectation queued");
            return;
        end
        f  = exp_q.pop_front();
        nm = name_q.pop_front();
        chk({nm, ".overflow"}, 32'(overflow), 32'(f.ovf));
        @(negedge clk);
        last_idx = 0;
        last_an  = an;
        for (int k = 0; k < N; k++) begin
            if (k > 0) begin
                n = 0;
                while (an === last_an && n < 4 * RDIV) begin
                    @(negedge clk);
                    n++;
                end
                if (an === last_an) begin
                    fail_bound({nm, ".scan_advance"});
                    return;
                end
            end
            last_an = an;
            zeros = 0;
            idx = 0;
            for (int i = 0; i < N; i++) begin
                if (an[i] === 1'b0) begin
                    zeros++;
                    idx = i;
                end
            end
            chk({nm, ".an_onehot"}, 32'(zeros), 32'd1);
            if (k > 0) chk({nm, ".scan_order"}, 32'(idx), 32'((last_idx + 1) % N));
            chk($sformatf("%s.seg[%0d]", nm, idx), 32'(seg), 32'(f.seg[idx]));
            chk($sformatf("%s.dp[%0d]", nm, idx), 32'(dp), 32'(f.dp_n[idx]));
            last_idx = idx;
        end
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            if ((prev_busy === 1'b1 && busy === 1'b0 && rst_n === 1'b1) || force_frame) begin
                force_frame = 1'b0;
                mon_active  = 1'b1;
                check_frame();
                mon_active  = 1'b0;
            end
            prev_busy = busy;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int n;
        repeat (3) @(negedge clk);
        chk("reset.an", 32'(an), 32'hF);
        chk("reset.seg", 32'(seg), 32'h7F);
        chk("reset.dp", 32'(dp), 32'd1);
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;

        // Unmapped address and a value-address cycle with WE low must not start anything.
        bus_write(BASE + 32'd8, 32'd77);
        @(negedge clk);
        WE = 1'b0; address = BASE; dataout = 32'd55;
        @(negedge clk);
        address = '0; dataout = '0;
        repeat (3) @(negedge clk);
        chk("ignored_write.busy", 32'(busy), 32'd0);

        // 1: decimal conversion and scan.
        push("t1_1234", L1, L2, L3, L4, 4'hF, 1'b0);
        bus_write(BASE, 32'd1234);
        measure_busy("t1.busy_cycles", 33);
        wait_idle();

        // 2: overflow shows dashes, then clears.
        push("t2_10000", LDASH, LDASH, LDASH, LDASH, 4'hF, 1'b1);
        bus_write(BASE, 32'd10000);
        measure_busy("t2.busy_cycles_ovf", 33);
        wait_idle();
        push("t2_9999", L9, L9, L9, L9, 4'hF, 1'b0);
        bus_write(BASE, 32'd9999);
        measure_busy("t2.busy_cycles", 33);
        wait_idle();

        // 3: leading-zero blanking, dp on blanked digit 1.
        bus_write(CTRL, 32'h0000_0203);
        push("t3_7", LBLANK, LBLANK, LBLANK, L7, 4'b1101, 1'b0);
        bus_write(BASE, 32'd7);
        measure_busy("t3.busy_cycles", 33);
        wait_idle();
        push("t3_0", LBLANK, LBLANK, LBLANK, L0, 4'b1101, 1'b0);
        bus_write(BASE, 32'd0);
        measure_busy("t3.busy_cycles_zero", 33);
        wait_idle();

        // 4: hex mode bypass and hex overflow.
        bus_write(CTRL, 32'h0000_0005);
        push("t4_beef", LB, LE, LE, LF, 4'hF, 1'b0);
        bus_write(BASE, 32'h0000_BEEF);
        measure_busy("t4.busy_cycles", 1);
        wait_idle();
        push("t4_1beef", LDASH, LDASH, LDASH, LDASH, 4'hF, 1'b1);
        bus_write(BASE, 32'h0001_BEEF);
        measure_busy("t4.busy_cycles_ovf", 1);
        wait_idle();

        // 5: restart mid-conversion; old display persists, only 0042 lands.
        bus_write(CTRL, 32'h0000_0001);
        push("t5_0042", L0, L0, L4, L2, 4'hF, 1'b0);
        bus_write(BASE, 32'd5555);
        n = 0;
        while (an !== 4'b1110 && n < 4 * N * RDIV) begin
            @(negedge clk);
            n++;
        end
        if (an !== 4'b1110) fail_bound("t5.wait_digit0");
        else chk("t5.old_display", 32'(seg), 32'(LDASH));
        chk("t5.busy_before_restart", 32'(busy), 32'd1);
        bus_write(BASE, 32'd42);
        measure_busy("t5.busy_cycles_restart", 34);
        wait_idle();

        // 6: asynchronous reset mid-conversion clears outputs, ctrl and overflow.
        bus_write(CTRL, 32'h0000_0803);
        push("t6_10000", LDASH, LDASH, LDASH, LDASH, 4'b0111, 1'b1);
        bus_write(BASE, 32'd10000);
        measure_busy("t6.busy_cycles_ovf", 33);
        wait_idle();
        bus_write(BASE, 32'd1234);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6.rst.an", 32'(an), 32'hF);
        chk("t6.rst.seg", 32'(seg), 32'h7F);
        chk("t6.rst.dp", 32'(dp), 32'd1);
        chk("t6.rst.busy", 32'(busy), 32'd0);
        chk("t6.rst.overflow", 32'(overflow), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push("t6_after_reset", L0, L0, L0, L0, 4'hF, 1'b0);
        force_frame = 1'b1;
        wait_idle();
        push("t6_1234", L1, L2, L3, L4, 4'hF, 1'b0);
        bus_write(BASE, 32'd1234);
        measure_busy("t6.busy_cycles", 33);
        wait_idle();

        chk("scoreboard.drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
